// File: rtl/ball_render_pkg.sv
// Shared types and constants for the ball render controller.
// Radius is stored at R_W_DEF bits inside ball_t.
package ball_render_pkg;

  localparam int NUM_BALLS_MAX = 4;
  localparam int COORD_W       = 10;
  localparam int R_W_DEF       = 6;

  typedef logic [1:0] ball_id_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [R_W_DEF-1:0] r;
    logic               en;
  } ball_t;

endpackage

// File: rtl/ball_render_ctrl_ball_hit_test.sv
// One ball's hit test: stage 1 registers dx/dy/r^2/en, stage 2 squares and compares.
// The hit output is combinational from the stage-1 registers; the parent registers it.
module ball_hit_test
  import ball_render_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  ball_t              ball,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic               hit
);

  localparam int D_W  = COORD_W + 1;
  localparam int D2_W = 2 * D_W;
  localparam int R2_W = 2 * R_W_DEF;

  logic signed [D_W-1:0]  dx_q;
  logic signed [D_W-1:0]  dy_q;
  logic        [R2_W-1:0] r2_q;
  logic                   en_q;

  // Ball parameters are captured with the pixel so a commit never affects it mid-flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dx_q <= '0;
      dy_q <= '0;
      r2_q <= '0;
      en_q <= 1'b0;
    end else begin
      dx_q <= {1'b0, DrawX} - {1'b0, ball.x};
      dy_q <= {1'b0, DrawY} - {1'b0, ball.y};
      r2_q <= R2_W'(ball.r) * R2_W'(ball.r);
      en_q <= ball.en;
    end
  end

  logic [COORD_W-1:0] adx;
  logic [COORD_W-1:0] ady;
  logic [D2_W-1:0]    d2;

  always_comb begin
    adx = dx_q[D_W-1] ? COORD_W'(-dx_q) : dx_q[COORD_W-1:0];
    ady = dy_q[D_W-1] ? COORD_W'(-dy_q) : dy_q[COORD_W-1:0];
    d2  = D2_W'(adx) * D2_W'(adx) + D2_W'(ady) * D2_W'(ady);
    hit = en_q && (d2 <= D2_W'(r2_q));
  end

endmodule

// File: rtl/ball_render_ctrl.sv
// Double-buffered ball registers committed at frame_start, plus a 2-stage per-pixel
// hit pipeline reporting the lowest-ID ball hit and whether several balls overlap.
module ball_render_ctrl
  import ball_render_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int R_W       = R_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [1:0]         upd_id,
  input  logic [COORD_W-1:0] upd_x,
  input  logic [COORD_W-1:0] upd_y,
  input  logic [R_W-1:0]     upd_r,
  input  logic               upd_en,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic               out_valid,
  output logic [COORD_W-1:0] DrawX_out,
  output logic [COORD_W-1:0] DrawY_out,
  output logic               is_ball,
  output ball_id_t           ballID,
  output logic               overlap
);

  ball_t shadow [NUM_BALLS];
  ball_t active [NUM_BALLS];

  // Writes are refused in the commit cycle so the committed set is unambiguous.
  assign upd_ready = !Reset && !frame_start;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (upd_valid && upd_ready && ({1'b0, upd_id} < 3'(NUM_BALLS)))
        shadow[upd_id] <= '{x: upd_x, y: upd_y, r: R_W_DEF'(upd_r), en: upd_en};
      if (frame_start)
        active <= shadow;
    end
  end

  logic [NUM_BALLS-1:0] hit;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
    ball_hit_test u_hit (
      .Clk   (Clk),
      .Reset (Reset),
      .ball  (active[g]),
      .DrawX (DrawX),
      .DrawY (DrawY),
      .hit   (hit[g])
    );
  end

  ball_id_t win_id;
  logic     any_hit;
  logic [2:0] hit_cnt;

  always_comb begin
    win_id  = '0;
    any_hit = |hit;
    hit_cnt = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--)
      if (hit[i]) win_id = ball_id_t'(i);
    for (int i = 0; i < NUM_BALLS; i++)
      hit_cnt = hit_cnt + 3'(hit[i]);
  end

  logic               v1;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1        <= 1'b0;
      x1        <= '0;
      y1        <= '0;
      out_valid <= 1'b0;
      DrawX_out <= '0;
      DrawY_out <= '0;
      is_ball   <= 1'b0;
      ballID    <= '0;
      overlap   <= 1'b0;
    end else begin
      v1        <= pix_valid;
      x1        <= DrawX;
      y1        <= DrawY;
      out_valid <= v1;
      DrawX_out <= x1;
      DrawY_out <= y1;
      is_ball   <= v1 && any_hit;
      ballID    <= (v1 && any_hit) ? win_id : '0;
      overlap   <= v1 && (hit_cnt >= 3'd2);
    end
  end

endmodule

// File: tb/tb_ball_render_ctrl.sv
// Directed bench for ball_render_ctrl: commit semantics, hit geometry, priority, reset.
module tb_ball_render_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [1:0] upd_id = '0;
  logic [9:0] upd_x = '0;
  logic [9:0] upd_y = '0;
  logic [5:0] upd_r = '0;
  logic       upd_en = 1'b0;
  logic       pix_valid = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       out_valid;
  logic [9:0] DrawX_out;
  logic [9:0] DrawY_out;
  logic       is_ball;
  logic [1:0] ballID;
  logic       overlap;

  int nvec = 0;
  int nerr = 0;

  ball_render_ctrl #(.NUM_BALLS(4), .R_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_id(upd_id),
    .upd_x(upd_x), .upd_y(upd_y), .upd_r(upd_r), .upd_en(upd_en),
    .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .out_valid(out_valid), .DrawX_out(DrawX_out), .DrawY_out(DrawY_out),
    .is_ball(is_ball), .ballID(ballID), .overlap(overlap)
  );

  always #5 Clk = ~Clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_ball(input logic [1:0] id, input int x, input int y, input int r, input logic en);
    @(negedge Clk);
    upd_valid = 1'b1; upd_id = id;
    upd_x = 10'(x); upd_y = 10'(y); upd_r = 6'(r); upd_en = en;
    @(negedge Clk);
    upd_valid = 1'b0;
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  // One isolated pixel; its result is visible on the second negedge after it is driven.
  task automatic probe(input string tag, input int x, input int y,
                       input logic eh, input logic [1:0] eid, input logic eov);
    @(negedge Clk);
    pix_valid = 1'b1; DrawX = 10'(x); DrawY = 10'(y);
    @(negedge Clk);
    pix_valid = 1'b0; DrawX = '0; DrawY = '0;
    expect_eq({tag, ".inflight_valid"}, 32'(out_valid), 32'(0));
    @(negedge Clk);
    expect_eq({tag, ".valid"}, 32'(out_valid), 32'(1));
    expect_eq({tag, ".x"}, 32'(DrawX_out), 32'(x));
    expect_eq({tag, ".y"}, 32'(DrawY_out), 32'(y));
    expect_eq({tag, ".is_ball"}, 32'(is_ball), 32'(eh));
    expect_eq({tag, ".id"}, 32'(ballID), 32'(eid));
    expect_eq({tag, ".overlap"}, 32'(overlap), 32'(eov));
  endtask

  int sx [3] = '{325, 326, 324};
  int sy [3] = '{240, 240, 243};
  logic sh [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    // Reset state
    repeat (2) @(negedge Clk);
    expect_eq("rst.out_valid", 32'(out_valid), 0);
    expect_eq("rst.is_ball", 32'(is_ball), 0);
    expect_eq("rst.ballID", 32'(ballID), 0);
    expect_eq("rst.overlap", 32'(overlap), 0);
    expect_eq("rst.DrawX_out", 32'(DrawX_out), 0);
    Reset = 1'b0;
    #1 expect_eq("rst.upd_ready", 32'(upd_ready), 1);

    // Written but not committed: no hit; after commit: hit on ball 0
    write_ball(2'd0, 100, 100, 10, 1'b1);
    probe("precommit", 100, 100, 1'b0, 2'd0, 1'b0);
    frame();
    probe("commit0", 100, 100, 1'b1, 2'd0, 1'b0);

    // Ball 2 at (320,240) r=5: streamed pixels d^2 = 25, 36, 25
    write_ball(2'd2, 320, 240, 5, 1'b1);
    frame();
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (k >= 2) begin
        expect_eq("stream.valid", 32'(out_valid), 1);
        expect_eq("stream.x", 32'(DrawX_out), 32'(sx[k-2]));
        expect_eq("stream.is_ball", 32'(is_ball), 32'(sh[k-2]));
        expect_eq("stream.id", 32'(ballID), sh[k-2] ? 32'd2 : 32'd0);
      end
      if (k < 3) begin
        pix_valid = 1'b1; DrawX = 10'(sx[k]); DrawY = 10'(sy[k]);
      end else begin
        pix_valid = 1'b0;
      end
    end

    // Overlapping balls 1 and 3: lowest id wins; inclusive edge of ball 1 alone
    write_ball(2'd1, 200, 200, 8, 1'b1);
    write_ball(2'd3, 204, 200, 8, 1'b1);
    frame();
    probe("overlap", 202, 200, 1'b1, 2'd1, 1'b1);
    probe("edge1", 192, 200, 1'b1, 2'd1, 1'b0);
    probe("edge3", 212, 200, 1'b1, 2'd3, 1'b0);
    probe("empty", 0, 0, 1'b0, 2'd0, 1'b0);

    // Write held across the commit cycle: refused there, accepted next, visible after next frame
    @(negedge Clk);
    frame_start = 1'b1; upd_valid = 1'b1; upd_id = 2'd0;
    upd_x = 10'd2; upd_y = 10'd50; upd_r = 6'd5; upd_en = 1'b1;
    #1 expect_eq("hs.ready_in_commit", 32'(upd_ready), 0);
    @(negedge Clk);
    frame_start = 1'b0;
    #1 expect_eq("hs.ready_after", 32'(upd_ready), 1);
    @(negedge Clk);
    upd_valid = 1'b0;
    probe("hs.not_yet", 0, 50, 1'b0, 2'd0, 1'b0);
    probe("hs.old_still", 100, 100, 1'b1, 2'd0, 1'b0);
    frame();
    probe("hs.neg_dx", 0, 50, 1'b1, 2'd0, 1'b0);

    // Disabled ball, radius 0, last-write-wins
    write_ball(2'd0, 2, 50, 5, 1'b0);
    write_ball(2'd1, 10, 10, 0, 1'b1);
    write_ball(2'd2, 400, 400, 5, 1'b1);
    write_ball(2'd2, 50, 60, 3, 1'b1);
    frame();
    probe("disabled", 0, 50, 1'b0, 2'd0, 1'b0);
    probe("r0.centre", 10, 10, 1'b1, 2'd1, 1'b0);
    probe("r0.next", 11, 10, 1'b0, 2'd0, 1'b0);
    probe("lww.new", 50, 60, 1'b1, 2'd2, 1'b0);
    probe("lww.old", 400, 400, 1'b0, 2'd0, 1'b0);

    // Pixel without pix_valid: evaluated but masked
    @(negedge Clk);
    pix_valid = 1'b0; DrawX = 10'd10; DrawY = 10'd10;
    repeat (2) @(negedge Clk);
    expect_eq("novalid.valid", 32'(out_valid), 0);
    expect_eq("novalid.is_ball", 32'(is_ball), 0);

    // Reset in the middle of a hitting stream, with an uncommitted write pending
    write_ball(2'd3, 300, 300, 4, 1'b1);
    @(negedge Clk);
    pix_valid = 1'b1; DrawX = 10'd10; DrawY = 10'd10;
    repeat (2) @(negedge Clk);
    expect_eq("mid.pre_is_ball", 32'(is_ball), 1);
    Reset = 1'b1;
    #1;
    expect_eq("mid.valid", 32'(out_valid), 0);
    expect_eq("mid.is_ball", 32'(is_ball), 0);
    expect_eq("mid.ballID", 32'(ballID), 0);
    expect_eq("mid.x", 32'(DrawX_out), 0);
    expect_eq("mid.ready", 32'(upd_ready), 0);
    @(negedge Clk);
    pix_valid = 1'b0; DrawX = '0; DrawY = '0;
    Reset = 1'b0;
    frame();
    probe("post.r0", 10, 10, 1'b0, 2'd0, 1'b0);
    probe("post.pending", 300, 300, 1'b0, 2'd0, 1'b0);
    probe("post.b0", 100, 100, 1'b0, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
